// File: rtl/pc_ifid_unit.sv
// Fetch-side control: PC register and IF/ID pipeline register.
// Next PC resolved in ID with an architectural branch delay slot.
module pc_ifid_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] instr_f,
    input  logic [2:0]  npc_op,
    input  logic        cmp_zero,
    input  logic [31:0] jr_target,
    output logic [31:0] pc_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        redirect
);

    localparam logic [2:0] OP_BEQ = 3'd1;
    localparam logic [2:0] OP_BNE = 3'd2;
    localparam logic [2:0] OP_J   = 3'd3;
    localparam logic [2:0] OP_JR  = 3'd4;

    logic [31:0] pc_d_plus4;
    logic [31:0] pc_f_plus4;
    logic [31:0] imm;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] npc;
    logic        is_jr;
    logic        is_j;
    logic        br_taken;

    assign pc_d_plus4 = pc_d + 32'd4;
    assign pc_f_plus4 = pc_f + 32'd4;
    assign pc8_d      = pc_d + 32'd8;
    assign imm        = {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
    assign br_target  = pc_d_plus4 + imm;
    assign j_target   = {pc_d_plus4[31:28], instr_d[25:0], 2'b00};

    assign is_jr    = (npc_op == OP_JR);
    assign is_j     = (npc_op == OP_J);
    assign br_taken = ((npc_op == OP_BEQ) && cmp_zero)
                   || ((npc_op == OP_BNE) && !cmp_zero);

    // Select the next fetch address from the ID-stage decision.
    always_comb begin
        npc      = pc_f_plus4;
        redirect = 1'b0;
        unique case (1'b1)
            is_jr: begin
                npc      = jr_target;
                redirect = 1'b1;
            end
            is_j: begin
                npc      = j_target;
                redirect = 1'b1;
            end
            br_taken: begin
                npc      = br_target;
                redirect = 1'b1;
            end
            default: begin
                npc      = pc_f_plus4;
                redirect = 1'b0;
            end
        endcase
    end

    // Advance PC and IF/ID unless stalled; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f    <= RESET_PC;
            instr_d <= NOP_INSTR;
            pc_d    <= 32'd0;
        end else if (!stall) begin
            pc_f    <= npc;
            instr_d <= instr_f;
            pc_d    <= pc_f;
        end
    end

endmodule

// File: tb/tb_pc_ifid_unit.sv
// Directed bench for pc_ifid_unit.
// Hand-computed expectations checked with immediate assertions.
module tb_pc_ifid_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] instr_f;
    logic [2:0]  npc_op;
    logic        cmp_zero;
    logic [31:0] jr_target;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        redirect;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] IA  = 32'hA000_0001;
    localparam logic [31:0] BEQ = 32'h1000_FFFE;
    localparam logic [31:0] IC  = 32'hC000_0003;
    localparam logic [31:0] ID  = 32'hD000_0004;
    localparam logic [31:0] JAL = 32'h0C00_0C10;
    localparam logic [31:0] IE  = 32'hE000_0005;
    localparam logic [31:0] BNE = 32'h1400_0003;

    pc_ifid_unit dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .instr_f   (instr_f),
        .npc_op    (npc_op),
        .cmp_zero  (cmp_zero),
        .jr_target (jr_target),
        .pc_f      (pc_f),
        .instr_d   (instr_d),
        .pc_d      (pc_d),
        .pc8_d     (pc8_d),
        .redirect  (redirect)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] e_pcf,
                             input logic [31:0] e_ins, input logic [31:0] e_pcd);
        chk({tag, ".pc_f"}, pc_f, e_pcf);
        chk({tag, ".instr_d"}, instr_d, e_ins);
        chk({tag, ".pc_d"}, pc_d, e_pcd);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b1; instr_f = 32'h1234_5678;
        npc_op = 3'd0; cmp_zero = 1'b0; jr_target = 32'd0;
        step();
        chk_state("rst", 32'h3000, 32'h0, 32'h0);
        chk("rst.pc8_d", pc8_d, 32'h8);
        chk("rst.redirect", {31'd0, redirect}, 32'd0);

        reset = 1'b0; stall = 1'b0; instr_f = IA;
        step();
        chk_state("seqA", 32'h3004, IA, 32'h3000);
        instr_f = BEQ;
        step();
        chk_state("seqB", 32'h3008, BEQ, 32'h3004);

        npc_op = 3'd1; cmp_zero = 1'b1; instr_f = IC;
        settle();
        chk("beqT.redirect", {31'd0, redirect}, 32'd1);
        step();
        chk_state("beqT", 32'h3000, IC, 32'h3008);

        npc_op = 3'd0; instr_f = IA;
        step();
        instr_f = BEQ;
        step();
        chk_state("seqB2", 32'h3008, BEQ, 32'h3004);
        npc_op = 3'd1; cmp_zero = 1'b0; instr_f = IC;
        settle();
        chk("beqN.redirect", {31'd0, redirect}, 32'd0);
        step();
        chk_state("beqN", 32'h300C, IC, 32'h3008);

        npc_op = 3'd0; instr_f = ID;
        step();
        instr_f = JAL;
        step();
        chk_state("jalID", 32'h3014, JAL, 32'h3010);
        chk("jal.pc8_d", pc8_d, 32'h3018);
        npc_op = 3'd3; instr_f = IE;
        settle();
        chk("jal.redirect", {31'd0, redirect}, 32'd1);
        step();
        chk_state("jal", 32'h3040, IE, 32'h3014);

        npc_op = 3'd4; jr_target = 32'h3100;
        step();
        chk("jr.pc_f", pc_f, 32'h3100);
        jr_target = 32'h3020;
        step();
        chk("jr2.pc_f", pc_f, 32'h3020);

        npc_op = 3'd0; instr_f = BNE;
        step();
        chk_state("bneID", 32'h3024, BNE, 32'h3020);
        npc_op = 3'd2; cmp_zero = 1'b1;
        settle();
        chk("bneN.redirect", {31'd0, redirect}, 32'd0);
        cmp_zero = 1'b0; instr_f = IE;
        settle();
        chk("bneT.redirect", {31'd0, redirect}, 32'd1);
        step();
        chk_state("bneT", 32'h3030, IE, 32'h3024);

        npc_op = 3'd0; instr_f = BEQ;
        step();
        chk_state("stlID", 32'h3034, BEQ, 32'h3030);
        stall = 1'b1; npc_op = 3'd1; cmp_zero = 1'b1; instr_f = IC;
        step();
        chk_state("stl1", 32'h3034, BEQ, 32'h3030);
        cmp_zero = 1'b0;
        step();
        chk_state("stl2", 32'h3034, BEQ, 32'h3030);
        stall = 1'b0;
        settle();
        chk("stlRel.redirect", {31'd0, redirect}, 32'd0);
        step();
        chk_state("stlRel", 32'h3038, IC, 32'h3034);

        npc_op = 3'd0; instr_f = BEQ;
        step();
        stall = 1'b1; npc_op = 3'd1; cmp_zero = 1'b1;
        step();
        chk_state("rstStl.hold", 32'h303C, BEQ, 32'h3038);
        reset = 1'b1;
        step();
        chk_state("rstStl", 32'h3000, 32'h0, 32'h0);
        reset = 1'b0; stall = 1'b0; npc_op = 3'd0; instr_f = IA;
        step();
        chk_state("postRst", 32'h3004, IA, 32'h3000);

        npc_op = 3'd4; jr_target = 32'hFFFF_FFFC;
        step();
        chk("wrapSet.pc_f", pc_f, 32'hFFFF_FFFC);
        npc_op = 3'd5; cmp_zero = 1'b1;
        settle();
        chk("op5.redirect", {31'd0, redirect}, 32'd0);
        step();
        chk("wrap.pc_f", pc_f, 32'h0);
        chk("wrap.pc_d", pc_d, 32'hFFFF_FFFC);
        chk("wrap.pc8_d", pc8_d, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
